// File: rtl/puf_ro_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// puf_ro_ctrl
// Evaluation controller for an array of ring-oscillator PUF cells. A request
// enables the two ROs named by the challenge pair and lets them settle. It then
// counts the rising edges of both ROs over a programmable window and reports
// which one ran faster.
//
// Ports
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_start             evaluation request, sampled only while idle
//   i_chal_a, i_chal_b  indices of the two ROs to compare
//   i_win               counting window length in clock cycles
//   i_ro                raw RO outputs, asynchronous to i_clk
//   o_ro_en             per-RO enable
//   o_busy              evaluation in progress
//   o_done              one-cycle pulse at the end of an evaluation
//   o_resp              response bit: 1 when RO a counted more edges than RO b
//   o_err               last accepted request was invalid
//   o_cnt_a, o_cnt_b    final saturated edge counts of RO a and RO b
// ----------------------------------------------------------------------------
module puf_ro_ctrl #(
    parameter int N_RO       = 16,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [SEL_W-1:0] i_chal_a,
    input  logic [SEL_W-1:0] i_chal_b,
    input  logic [WIN_W-1:0] i_win,
    input  logic [N_RO-1:0]  i_ro,
    output logic [N_RO-1:0]  o_ro_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_resp,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b
);

    // The challenge space may be wider than the RO array. Edge and enable
    // vectors are padded to the full index range so that any index value
    // selects a defined bit.
    localparam int               SEL_SPAN    = 2 ** SEL_W;
    localparam logic [SEL_W:0]   RO_LIMIT    = (SEL_W + 1)'(N_RO);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [N_RO-1:0]     ro_meta_q;
    logic [N_RO-1:0]     ro_sync_q;
    logic [N_RO-1:0]     ro_prev_q;
    logic [SEL_W-1:0]    sel_a_q;
    logic [SEL_W-1:0]    sel_b_q;
    logic [WIN_W-1:0]    win_left_q;
    logic [7:0]          settle_q;
    logic [CNT_W-1:0]    cnt_a_q;
    logic [CNT_W-1:0]    cnt_b_q;
    logic [CNT_W-1:0]    cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_d;
    logic [SEL_SPAN-1:0] rise_pad;
    logic [SEL_SPAN-1:0] hot_a;
    logic [SEL_SPAN-1:0] hot_b;
    logic                req_ok;

    // Two-flop synchronizer plus one history stage for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ro_meta_q <= '0;
            ro_sync_q <= '0;
            ro_prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value; blocking ones would collapse the chain.
            ro_meta_q <= i_ro;
            ro_sync_q <= ro_meta_q;
            ro_prev_q <= ro_sync_q;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any condition so that no
        // path leaves it unassigned and no latch is inferred.
        rise_pad = SEL_SPAN'(ro_sync_q & ~ro_prev_q);
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        // Saturating increments: hold at all-ones instead of wrapping.
        if (rise_pad[sel_a_q] && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (rise_pad[sel_b_q] && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);

        hot_a  = SEL_SPAN'(1) << i_chal_a;
        hot_b  = SEL_SPAN'(1) << i_chal_b;
        req_ok = (i_chal_a != i_chal_b) &&
                 ({1'b0, i_chal_a} < RO_LIMIT) &&
                 ({1'b0, i_chal_b} < RO_LIMIT) &&
                 (i_win != '0);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            win_left_q <= '0;
            settle_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            o_ro_en    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_resp     <= 1'b0;
            o_err      <= 1'b0;
            o_cnt_a    <= '0;
            o_cnt_b    <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        sel_a_q    <= i_chal_a;
                        sel_b_q    <= i_chal_b;
                        win_left_q <= i_win;
                        if (req_ok) begin
                            o_err    <= 1'b0;
                            cnt_a_q  <= '0;
                            cnt_b_q  <= '0;
                            o_ro_en  <= hot_a[N_RO-1:0] | hot_b[N_RO-1:0];
                            settle_q <= SETTLE_LOAD;
                            o_busy   <= 1'b1;
                            state_q  <= S_SETTLE;
                        end else begin
                            // Rejected requests leave enables, counts and
                            // response untouched and finish right away.
                            o_err   <= 1'b1;
                            o_done  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_q == 8'd0) state_q <= S_COUNT;
                    else                  settle_q <= settle_q - 8'd1;
                end
                S_COUNT: begin
                    cnt_a_q <= cnt_a_d;
                    cnt_b_q <= cnt_b_d;
                    // The latched window is at least 1; its last cycle is
                    // the one that sees the value 1.
                    if (win_left_q == WIN_W'(1)) state_q <= S_COMPARE;
                    else                         win_left_q <= win_left_q - WIN_W'(1);
                end
                S_COMPARE: begin
                    o_resp  <= (cnt_a_q > cnt_b_q);
                    o_cnt_a <= cnt_a_q;
                    o_cnt_b <= cnt_b_q;
                    o_ro_en <= '0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_ro_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_puf_ro_ctrl
// Directed and randomized evaluations of puf_ro_ctrl. Behavioural RO cells run
// only while enabled. The reference count for each RO is the number of rising
// edges it produced during the counting window, in wall-clock terms. The DUT
// must match it within one edge, because synchronizer delay shifts its window.
// A second instance with 4-bit counters covers saturation on the same stimulus.
// ----------------------------------------------------------------------------
module tb_puf_ro_ctrl;

    localparam int N_RO       = 16;
    localparam int SEL_W      = 5;
    localparam int CNT_W      = 16;
    localparam int SAT_W      = 4;
    localparam int WIN_W      = 16;
    localparam int SETTLE_CYC = 8;
    localparam int SAT_MAX    = 15;
    localparam int CNT_MAX    = 65535;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             start  = 1'b0;
    logic [SEL_W-1:0] chal_a = '0;
    logic [SEL_W-1:0] chal_b = '0;
    logic [WIN_W-1:0] win    = '0;
    logic [N_RO-1:0]  ro;
    logic             ro_bit [N_RO];

    logic [N_RO-1:0]  ro_en, ro_en_s;
    logic             busy, done, resp, err;
    logic             busy_s, done_s, resp_s, err_s;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [SAT_W-1:0] cnt_a_s, cnt_b_s;

    int hp    [N_RO];   // RO half-period in ns
    int edges [N_RO];   // rising edges produced by each RO so far

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int last_ma = 0, last_mb = 0, last_resp = 0;
    bit last_resp_known = 1'b1;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_RO; i++) ro[i] = ro_bit[i];
    end

    always @(posedge clk) if (done === 1'b1) done_seen++;

    puf_ro_ctrl #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W),
                  .SETTLE_CYC(SETTLE_CYC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_chal_a(chal_a),
        .i_chal_b(chal_b), .i_win(win), .i_ro(ro), .o_ro_en(ro_en),
        .o_busy(busy), .o_done(done), .o_resp(resp), .o_err(err),
        .o_cnt_a(cnt_a), .o_cnt_b(cnt_b));

    puf_ro_ctrl #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(SAT_W), .WIN_W(WIN_W),
                  .SETTLE_CYC(SETTLE_CYC)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_chal_a(chal_a),
        .i_chal_b(chal_b), .i_win(win), .i_ro(ro), .o_ro_en(ro_en_s),
        .o_busy(busy_s), .o_done(done_s), .o_resp(resp_s), .o_err(err_s),
        .o_cnt_a(cnt_a_s), .o_cnt_b(cnt_b_s));

    // Behavioural RO cells: they oscillate only while enabled.
    for (genvar g = 0; g < N_RO; g++) begin : g_ro
        initial begin
            ro_bit[g] = 1'b0;
            edges[g]  = 0;
            forever begin
                if (ro_en[g] === 1'b1 && hp[g] > 0) begin
                    #(hp[g]);
                    ro_bit[g] = ~ro_bit[g];
                    if (ro_bit[g]) edges[g]++;
                end else begin
                    ro_bit[g] = 1'b0;
                    #1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count within one edge of the reference, clipped to the counter range.
    task automatic check_rng(input string tag, input int obs, input int exp, input int max);
        int lo, hi;
        bit ok;
        lo = (exp - 1 < 0) ? 0 : exp - 1;
        hi = exp + 1;
        if (lo > max) lo = max;
        if (hi > max) hi = max;
        ok = (obs >= lo) && (obs <= hi);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One valid evaluation. exp_resp < 0 derives the response from the
    // reference counts. poke re-requests during SETTLE, COUNT and DONE.
    task automatic eval_valid(input string tag, input int a, input int b, input int w,
                              input int exp_resp, input bit poke);
        logic [N_RO-1:0] en_exp;
        int lat, a0, b0, ma, mb, want;
        bit got;
        en_exp = '0;
        en_exp[a] = 1'b1;
        en_exp[b] = 1'b1;
        lat = 0; a0 = 0; b0 = 0; ma = 0; mb = 0; got = 1'b0;
        @(negedge clk);
        chal_a = SEL_W'(a); chal_b = SEL_W'(b); win = WIN_W'(w); start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        chal_a = SEL_W'($urandom);
        chal_b = SEL_W'($urandom);
        win    = WIN_W'($urandom);
        while (!got && lat < SETTLE_CYC + w + 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                check({tag, " ro_en"}, 32'(ro_en), 32'(en_exp));
                check({tag, " busy_settle"}, 32'(busy), 32'd1);
            end
            if (lat == SETTLE_CYC + 1) begin a0 = edges[a]; b0 = edges[b]; end
            if (lat == SETTLE_CYC + 2) check({tag, " busy_count"}, 32'(busy), 32'd1);
            if (lat == SETTLE_CYC + w + 1) begin ma = edges[a] - a0; mb = edges[b] - b0; end
            if (poke) begin
                if (lat == 3 || lat == SETTLE_CYC + 3) begin
                    start  = 1'b1;
                    chal_a = SEL_W'((a + 1) % N_RO);
                    chal_b = SEL_W'((b + 5) % N_RO);
                    win    = WIN_W'(7);
                end else begin
                    start = 1'b0;
                end
            end
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(SETTLE_CYC + w + 2));
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " ro_en_off"}, 32'(ro_en), 32'd0);
        check({tag, " sat_done"}, 32'(done_s), 32'd1);
        check_rng({tag, " cnt_a"}, int'(cnt_a), ma, CNT_MAX);
        check_rng({tag, " cnt_b"}, int'(cnt_b), mb, CNT_MAX);
        check_rng({tag, " sat_cnt_a"}, int'(cnt_a_s), ma, SAT_MAX);
        check_rng({tag, " sat_cnt_b"}, int'(cnt_b_s), mb, SAT_MAX);
        want = exp_resp;
        if (want < 0) want = (ma - mb >= 3) ? 1 : ((mb - ma >= 3) ? 0 : -1);
        if (want >= 0) check({tag, " resp"}, 32'(resp), 32'(want));
        last_ma = ma;
        last_mb = mb;
        last_resp = want;
        last_resp_known = (want >= 0);
        if (poke && got) begin
            // A request during the DONE cycle must be dropped.
            start = 1'b1; chal_a = SEL_W'(0); chal_b = SEL_W'(1); win = WIN_W'(30);
            @(negedge clk);
            start = 1'b0;
            check({tag, " done_poke_busy"}, 32'(busy), 32'd0);
            check({tag, " done_poke_en"}, 32'(ro_en), 32'd0);
        end
    endtask

    task automatic eval_invalid(input string tag, input int a, input int b, input int w);
        @(negedge clk);
        chal_a = SEL_W'(a); chal_b = SEL_W'(b); win = WIN_W'(w); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " done_cycle1"}, 32'(done), 32'd1);
        check({tag, " err"}, 32'(err), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " ro_en"}, 32'(ro_en), 32'd0);
        if (last_resp_known) check({tag, " resp_hold"}, 32'(resp), 32'(last_resp));
        check_rng({tag, " cnt_a_hold"}, int'(cnt_a), last_ma, CNT_MAX);
        check_rng({tag, " cnt_b_hold"}, int'(cnt_b), last_mb, CNT_MAX);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int a, b, w, ha, hb, tries, seen0;
        real da;
        #3 rst_n = 1'b0;
        #20;
        check("reset ro_en", 32'(ro_en), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset resp", 32'(resp), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset cnt_a", 32'(cnt_a), 32'd0);
        check("reset cnt_b", 32'(cnt_b), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // RO3 period 40 ns, RO7 period 60 ns: about 30 and 20 edges in 120 cycles.
        hp[3] = 20;
        hp[7] = 30;
        eval_valid("basic", 3, 7, 120, 1, 1'b0);
        eval_valid("swapped", 7, 3, 120, 0, 1'b0);

        eval_invalid("inv_same", 5, 5, 50);
        eval_invalid("inv_range", 16, 2, 50);
        eval_invalid("inv_win0", 1, 2, 0);

        // Identical waveforms on both ROs must tie, and a tie reads as 0.
        hp[4]  = 25;
        hp[11] = 25;
        eval_valid("tie", 4, 11, 100, 0, 1'b0);

        // 40 ns RO over 200 cycles gives 50 edges: the 4-bit copy must hold 15.
        hp[6] = 20;
        hp[1] = 120;
        eval_valid("sat", 6, 1, 200, 1, 1'b0);
        check("sat exact", 32'(cnt_a_s), 32'd15);

        eval_valid("busy_prot", 3, 7, 120, 1, 1'b1);

        for (int k = 0; k < 5; k++) begin
            a = $urandom_range(0, N_RO - 1);
            b = a;
            while (b == a) b = $urandom_range(0, N_RO - 1);
            tries = 0;
            do begin
                ha = $urandom_range(20, 60);
                hb = $urandom_range(20, 60);
                w  = $urandom_range(40, 150);
                da = (w * 5.0) / ha - (w * 5.0) / hb;
                if (da < 0.0) da = -da;
                tries++;
            end while (da < 4.0 && tries < 100);
            hp[a] = ha;
            hp[b] = hb;
            eval_valid($sformatf("rnd%0d", k), a, b, w, -1, k[0]);
        end

        // Abort mid-count: everything drops at once and no done follows.
        hp[2] = 20;
        hp[9] = 45;
        @(negedge clk);
        chal_a = SEL_W'(2); chal_b = SEL_W'(9); win = WIN_W'(50); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (SETTLE_CYC + 10) @(posedge clk);
        seen0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        check("abort ro_en", 32'(ro_en), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort cnt_a", 32'(cnt_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort no_done", 32'(done_seen), 32'(seen0));
        last_ma = 0;
        last_mb = 0;
        last_resp = 0;
        last_resp_known = 1'b1;
        eval_valid("post_reset", 2, 9, 60, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
